// File: rtl/data_sram_responder_if.sv
// Request/response bundle between a pipeline load/store unit and the data SRAM responder.
interface data_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wstrb, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, addr, wstrb, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_sram_responder.sv
// Word-addressed data SRAM model with a fixed-latency, in-order response queue.
// Loads snapshot memory and stores commit at the accepting edge; the queue only times the reply.
module data_sram_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input logic                  clk,
  input logic                  reset,
  data_sram_responder_if.slave bus
);
  localparam int         QN      = 4;
  localparam logic [2:0] LAT_C   = 3'(LATENCY);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [1:0] LAST_C  = 2'(DEPTH - 1);

  logic [31:0]   mem [2**AW];
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   resp_word;
  logic [2:0]    count;
  logic [1:0]    head;
  logic [1:0]    tail;
  logic [QN-1:0] q_valid;
  logic [QN-1:0] q_load;
  logic [2:0]    q_cnt  [QN];
  logic [31:0]   q_data [QN];
  logic          accept;
  logic          head_due;
  logic          retire;
  logic          unused_bits;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == LAST_C) ? 2'd0 : p + 2'd1;
  endfunction

  assign idx         = bus.addr[AW+1:2];
  assign rd_word     = mem[idx];
  assign bus.addr_ok = (count < DEPTH_C);
  assign accept      = bus.req && bus.addr_ok;

  // The reply register is loaded one edge before the countdown expires, so data_ok
  // lands in the LATENCY-th cycle after the request cycle. LATENCY=1 bypasses the queue.
  assign head_due  = q_valid[head] && (q_cnt[head] == 3'd2);
  assign retire    = (LATENCY == 1) ? accept : head_due;
  assign resp_word = (LATENCY == 1) ? (bus.wr ? 32'h0 : rd_word)
                                    : (q_load[head] ? q_data[head] : 32'h0);

  assign unused_bits = &{1'b0, bus.size, bus.addr[31:AW+2], bus.addr[1:0]};

  // Memory is intentionally never reset.
  always_ff @(posedge clk) begin
    if (!reset && accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= 3'd0;
      head        <= 2'd0;
      tail        <= 2'd0;
      q_valid     <= '0;
      q_load      <= '0;
      bus.data_ok <= 1'b0;
      bus.rdata   <= 32'h0;
      for (int i = 0; i < QN; i++) begin
        q_cnt[i]  <= 3'd0;
        q_data[i] <= 32'h0;
      end
    end else begin
      bus.data_ok <= retire;
      if (retire) bus.rdata <= resp_word;

      for (int i = 0; i < QN; i++) begin
        if (q_valid[i] && q_cnt[i] != 3'd0) q_cnt[i] <= q_cnt[i] - 3'd1;
      end

      if (head_due) begin
        q_valid[head] <= 1'b0;
        head          <= nxt(head);
      end

      // tail never equals a retiring head: acceptance is refused when the queue is full.
      if (accept && LATENCY != 1) begin
        q_valid[tail] <= 1'b1;
        q_cnt[tail]   <= LAT_C;
        q_load[tail]  <= !bus.wr;
        q_data[tail]  <= bus.wr ? 32'h0 : rd_word;
        tail          <= nxt(tail);
      end

      case ({accept && LATENCY != 1, head_due})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder across three latency/depth configurations.
module tb_data_sram_responder;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  data_sram_responder_if a_bus ();
  data_sram_responder_if b_bus ();
  data_sram_responder_if c_bus ();

  data_sram_responder #(.AW(10), .LATENCY(2), .DEPTH(2)) dut_a (.clk(clk), .reset(reset), .bus(a_bus));
  data_sram_responder #(.AW(10), .LATENCY(3), .DEPTH(1)) dut_b (.clk(clk), .reset(reset), .bus(b_bus));
  data_sram_responder #(.AW(10), .LATENCY(5), .DEPTH(3)) dut_c (.clk(clk), .reset(reset), .bus(c_bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic r, input logic w, input logic [31:0] ad,
                       input logic [3:0] st, input logic [31:0] wd);
    a_bus.req = r; a_bus.wr = w; a_bus.size = 2'd2;
    a_bus.addr = ad; a_bus.wstrb = st; a_bus.wdata = wd;
  endtask

  task automatic drv_b(input logic r, input logic w, input logic [31:0] ad,
                       input logic [3:0] st, input logic [31:0] wd);
    b_bus.req = r; b_bus.wr = w; b_bus.size = 2'd2;
    b_bus.addr = ad; b_bus.wstrb = st; b_bus.wdata = wd;
  endtask

  task automatic drv_c(input logic r, input logic w, input logic [31:0] ad,
                       input logic [3:0] st, input logic [31:0] wd);
    c_bus.req = r; c_bus.wr = w; c_bus.size = 2'd2;
    c_bus.addr = ad; c_bus.wstrb = st; c_bus.wdata = wd;
  endtask

  initial begin
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    drv_c(0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_data_ok", a_bus.data_ok, 0);
    check("rst_rdata", a_bus.rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_addr_ok_a", a_bus.addr_ok, 1);
    check("rst_addr_ok_b", b_bus.addr_ok, 1);
    check("rst_addr_ok_c", c_bus.addr_ok, 1);

    // full store then dependent load
    drv_a(1, 1, 32'h10, 4'hF, 32'h12345678);
    @(negedge clk);
    check("st_no_resp_yet", a_bus.data_ok, 0);
    check("st_addr_ok", a_bus.addr_ok, 1);
    drv_a(1, 0, 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    check("st_resp", a_bus.data_ok, 1);
    check("st_rdata", a_bus.rdata, 32'h0);
    drv_a(0, 0, 0, 0, 0);
    @(negedge clk);
    check("ld_resp", a_bus.data_ok, 1);
    check("ld_rdata", a_bus.rdata, 32'h12345678);
    @(negedge clk);
    check("ld_pulse_end", a_bus.data_ok, 0);
    check("rdata_hold", a_bus.rdata, 32'h12345678);

    // partial store, byte-sized load returns full word
    drv_a(1, 1, 32'h10, 4'b0100, 32'h00AB0000);
    @(negedge clk);
    drv_a(1, 0, 32'h13, 4'h0, 32'h0);
    a_bus.size = 2'd0;
    @(negedge clk);
    drv_a(0, 0, 0, 0, 0);
    check("pst_resp", a_bus.data_ok, 1);
    check("pst_rdata", a_bus.rdata, 32'h0);
    @(negedge clk);
    check("pld_resp", a_bus.data_ok, 1);
    check("pld_rdata", a_bus.rdata, 32'h12AB5678);
    @(negedge clk);
    check("pld_pulse_end", a_bus.data_ok, 0);

    // wstrb=0 store still answers; aliased address reads the same word
    drv_a(1, 1, 32'h10, 4'h0, 32'hFFFFFFFF);
    @(negedge clk);
    drv_a(1, 0, 32'h1010, 4'h0, 32'h0);
    @(negedge clk);
    drv_a(0, 0, 0, 0, 0);
    check("z_st_resp", a_bus.data_ok, 1);
    check("z_st_rdata", a_bus.rdata, 32'h0);
    @(negedge clk);
    check("alias_resp", a_bus.data_ok, 1);
    check("alias_rdata", a_bus.rdata, 32'h12AB5678);
    @(negedge clk);

    // req held high: four stores then four loads, no stall
    for (int i = 0; i < 10; i++) begin
      if (i < 8) check("b2b_addr_ok", a_bus.addr_ok, 1);
      check("b2b_data_ok", a_bus.data_ok, (i >= 2) ? 32'd1 : 32'd0);
      if (i >= 6)      check("b2b_ld_rdata", a_bus.rdata, 32'hA5000000 + 32'(i - 6));
      else if (i >= 2) check("b2b_st_rdata", a_bus.rdata, 32'h0);
      if (i < 4)      drv_a(1, 1, 32'(i * 4), 4'hF, 32'hA5000000 + 32'(i));
      else if (i < 8) drv_a(1, 0, 32'((i - 4) * 4), 4'h0, 32'h0);
      else            drv_a(0, 0, 0, 0, 0);
      @(negedge clk);
    end
    check("b2b_done", a_bus.data_ok, 0);

    // load snapshot is not disturbed by a later store to the same word
    drv_a(1, 1, 32'h20, 4'hF, 32'h5A5A1234);
    @(negedge clk);
    drv_a(1, 0, 32'h20, 4'h0, 32'h0);
    @(negedge clk);
    check("snap_st0", a_bus.rdata, 32'h0);
    drv_a(1, 1, 32'h20, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    check("snap_old", a_bus.rdata, 32'h5A5A1234);
    drv_a(1, 0, 32'h20, 4'h0, 32'h0);
    @(negedge clk);
    check("snap_st1", a_bus.rdata, 32'h0);
    drv_a(0, 0, 0, 0, 0);
    @(negedge clk);
    check("snap_new_resp", a_bus.data_ok, 1);
    check("snap_new", a_bus.rdata, 32'hFFFFFFFF);
    @(negedge clk);
    check("snap_done", a_bus.data_ok, 0);

    // DEPTH=1, LATENCY=3: one acceptance every three cycles
    for (int i = 0; i < 11; i++) begin
      if (i <= 9) check("d1_addr_ok", b_bus.addr_ok, (i % 3 == 0) ? 32'd1 : 32'd0);
      check("d1_data_ok", b_bus.data_ok, (i >= 3 && i % 3 == 0) ? 32'd1 : 32'd0);
      if (i == 9)                check("d1_ld_rdata", b_bus.rdata, 32'hCAFE0001);
      else if (i == 3 || i == 6) check("d1_st_rdata", b_bus.rdata, 32'h0);
      if (i > 6)            drv_b(0, 0, 0, 0, 0);
      else if (i == 0)      drv_b(1, 1, 32'h40, 4'hF, 32'hCAFE0001);
      else if (i <= 3)      drv_b(1, 1, 32'h44, 4'hF, 32'hCAFE0002);
      else                  drv_b(1, 0, 32'h40, 4'h0, 32'h0);
      @(negedge clk);
    end

    // LATENCY=5, DEPTH=3: reset drops outstanding requests, memory survives
    drv_c(1, 1, 32'h08, 4'hF, 32'h0BADF00D);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 1) drv_c(0, 0, 0, 0, 0);
      check("c_st_data_ok", c_bus.data_ok, (j == 5) ? 32'd1 : 32'd0);
    end
    check("c_st_rdata", c_bus.rdata, 32'h0);
    @(negedge clk);
    drv_c(1, 0, 32'h08, 4'h0, 32'h0);
    @(negedge clk);
    drv_c(1, 0, 32'h0C, 4'h0, 32'h0);
    @(negedge clk);
    check("c_two_outstanding_addr_ok", c_bus.addr_ok, 1);
    drv_c(0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("c_rst_data_ok", c_bus.data_ok, 0);
    check("c_rst_addr_ok", c_bus.addr_ok, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("c_dropped_data_ok", c_bus.data_ok, 0);
      check("c_post_rst_addr_ok", c_bus.addr_ok, 1);
    end
    drv_c(1, 0, 32'h08, 4'h0, 32'h0);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 1) drv_c(0, 0, 0, 0, 0);
      check("c_ld_data_ok", c_bus.data_ok, (j == 5) ? 32'd1 : 32'd0);
    end
    check("c_mem_kept", c_bus.rdata, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter AW, default 10, meaning word-index width (memory holds 2^AW 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to data_ok (legal 1..7).
REQ-003 SHALL have parameter DEPTH, default 2, meaning maximum outstanding accepted requests (legal 1..4).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  1  request valid from pipeline.
REQ-007 SHALL have port wr  input  1  1 = store, 0 = load.
REQ-008 SHALL have port size  input  2  access size (0 byte, 1 half, 2 word), recorded only.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port wstrb  input  4  store byte-lane enables.
REQ-011 SHALL have port wdata  input  32  store data, lane-aligned.
REQ-012 SHALL have port addr_ok  output  1  request accepted this cycle when high with req.
REQ-013 SHALL have port data_ok  output  1  one-cycle response pulse.
REQ-014 SHALL have port rdata  output  32  full aligned load word, valid when data_ok.

Function
REQ-015 SHALL accept a request exactly on a rising edge where req && addr_ok.
REQ-016 SHALL drive addr_ok = (outstanding count < DEPTH), registered-state only, no combinational path from req or data_ok.
REQ-017 SHALL refuse acceptance when count == DEPTH even if a response retires the same cycle.
REQ-018 SHALL index memory by addr[AW+1:2]; upper address bits ignored (aliasing wrap).
REQ-019 SHALL commit a store at the accepting edge, updating only byte lanes with wstrb bit set; wstrb = 0 leaves memory unchanged but still produces a response.
REQ-020 SHALL snapshot a load's word at the accepting edge; a later-accepted store to the same word does not alter that load's rdata.
REQ-021 SHALL, for a load accepted in the same cycle a prior store is accepted, never occur (one acceptance per cycle); a load accepted after a store returns the stored data.
REQ-022 SHALL return the full 32-bit word regardless of size and addr[1:0]; byte/half extraction and extension belong to the consumer.
REQ-023 SHALL hold each accepted request in an in-order queue of DEPTH entries with a per-entry countdown loaded with LATENCY.
REQ-024 SHALL decrement every valid entry's countdown each cycle, saturating at 0.
REQ-025 SHALL assert data_ok for exactly one cycle, registered, exactly LATENCY cycles after the accepting edge of the head entry, then pop it.
REQ-026 SHALL respond strictly in acceptance order, at most one data_ok per cycle.
REQ-027 SHALL drive rdata with the snapshot word for loads and 32'h0 for stores during data_ok; rdata holds its last value otherwise.
REQ-028 SHALL handle simultaneous accept and retire (count < DEPTH) with count unchanged.
REQ-029 SHALL sustain one request per cycle when DEPTH >= LATENCY.

Reset
REQ-030 SHALL, on reset assertion at any time, immediately clear all queue entries and the count, dropping outstanding requests without data_ok.
REQ-031 SHALL reset data_ok = 0, rdata = 32'h0, addr_ok = 1 (after reset deasserts).
REQ-032 SHALL not reset memory contents; stores committed before reset persist.

Verification
REQ-033 Store addr=0x10, wstrb=4'b1111, wdata=0x12345678 at cycle t; load addr=0x10 at t+1 -> data_ok at t+1+LATENCY with rdata=0x12345678; store's data_ok at t+LATENCY with rdata=0.
REQ-034 Partial store addr=0x10, wstrb=4'b0100, wdata=0x00AB0000 over 0x12345678; load addr=0x13, size=0 -> rdata=0x12AB5678.
REQ-035 DEPTH=2, LATENCY=2, req held high with loads 0x0,0x4,0x8,0xC -> addr_ok never drops, four back-to-back data_ok pulses, in order.
REQ-036 DEPTH=1, LATENCY=3, req held high -> addr_ok low while one outstanding, one acceptance every 3 cycles, no simultaneous accept/retire.
REQ-037 Load 0x20 accepted, store 0x20 wdata=0xFFFFFFFF accepted next cycle -> load returns old value; subsequent load returns 0xFFFFFFFF.
REQ-038 Two requests outstanding, reset pulsed one cycle -> no data_ok ever for them, addr_ok=1 after reset, memory contents intact on next load.
